approx_mul_ha_pipe: RTL and testbench

- Parametrised, pipelined unsigned WxW multiplier built on the paired-row half-adder array scheme.
- Partial-product rows are paired as (2k, 2k+1). Each pair is compressed by a row of half adders. In approximate mode, the low pair-local columns use OR-only cells with the carry dropped.
- A final exact accumulation stage sums the W/2 pair arrays into the 2W-bit product.
- Sits between operand producers and the accuracy/energy evaluation datapath. Uses valid/ready on both sides and carries a per-transaction exact/approx mode bit.

---
 rtl/approx_mul_ha_pipe.sv | 138 +++++++++++++
 tb/tb_approx_mul_ha_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_ha_pipe.sv
// Pipelined unsigned WxW multiplier built from paired partial-product rows, each pair
// compressed by a half-adder row whose low columns can switch to carry-free OR cells.
module approx_mul_ha_pipe #(
    parameter int W           = 8,
    parameter int APPROX_COLS = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_prod,
    output logic             out_approx,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] approx_cnt
);
    localparam int NP   = W / 2;
    localparam int PV_W = W + 2;
    localparam int PW   = 2 * W;

    if ((W % 2) != 0 || W < 4) begin : g_bad_w
        $error("approx_mul_ha_pipe: W must be even and >= 4");
    end
    if (APPROX_COLS < 1 || APPROX_COLS > W) begin : g_bad_cols
        $error("approx_mul_ha_pipe: APPROX_COLS must be in 1..W");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              w_en;
    logic              r_vld_p1, r_vld_p2, r_vld_p3;
    logic              r_apx_p1, r_apx_p2, r_apx_p3;
    logic [W-1:0]      r_x_p1, r_y_p1;
    logic [NP*PV_W-1:0] w_pv_all;
    logic [PW-1:0]     w_prod;

    // The whole pipe moves in lockstep; a stalled output freezes every stage.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else if (w_en) begin
            r_vld_p1 <= in_valid;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
        end
    end

    // S1: operand capture
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_x_p1   <= in_x;
            r_y_p1   <= in_y;
            r_apx_p1 <= in_approx;
            r_apx_p2 <= r_apx_p1;
            r_apx_p3 <= r_apx_p2;
        end
    end

    for (genvar k = 0; k < NP; k++) begin : g_pair
        logic [W-1:0]    w_top, w_bot;
        logic [W:0]      w_sum, w_car;
        logic [W:0]      r_sum_p2, r_car_p2;
        logic [PV_W-1:0] r_pv_p3;

        assign w_top = r_y_p1 & {W{r_x_p1[2*k]}};
        assign w_bot = r_y_p1 & {W{r_x_p1[2*k+1]}};

        // S2: half-adder row; bottom row is offset by one column
        always_comb begin
            w_sum    = '0;
            w_car    = '0;
            w_sum[0] = w_top[0];
            w_sum[W] = w_bot[W-1];
            for (int j = 1; j < W; j++) begin
                if (r_apx_p1 && j < APPROX_COLS) begin
                    w_sum[j] = w_top[j] | w_bot[j-1];
                end else begin
                    w_sum[j]   = w_top[j] ^ w_bot[j-1];
                    w_car[j+1] = w_top[j] & w_bot[j-1];
                end
            end
        end

        // S3: carries already sit at their column weight, so a plain add gives the pair value
        always_ff @(posedge clk) begin
            if (w_en) begin
                r_sum_p2 <= w_sum;
                r_car_p2 <= w_car;
                r_pv_p3  <= PV_W'(r_sum_p2) + PV_W'(r_car_p2);
            end
        end

        assign w_pv_all[k*PV_W +: PV_W] = r_pv_p3;
    end

    always_comb begin
        w_prod = '0;
        for (int k = 0; k < NP; k++) begin
            w_prod = w_prod + (PW'(w_pv_all[k*PV_W +: PV_W]) << (2 * k));
        end
    end

    // Output stage: exact accumulation of the weighted pair values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_prod   <= '0;
            out_approx <= 1'b0;
        end else if (w_en) begin
            out_valid  <= r_vld_p3;
            out_prod   <= w_prod;
            out_approx <= r_apx_p3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            approx_cnt <= '0;
        end else if (cnt_clr) begin
            approx_cnt <= '0;
        end else if (out_valid && out_ready && out_approx) begin
            approx_cnt <= sat_inc(approx_cnt);
        end
    end

endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// Scoreboard bench for approx_mul_ha_pipe: directed W=8 scenarios plus random
// exact-mode streams on W=4 and W=12 instances running alongside.
module tb_approx_mul_ha_pipe;
    localparam int W  = 8;
    localparam int AC = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid, in_ready, in_approx;
    logic [W-1:0]  in_x, in_y;
    logic          out_valid, out_ready, out_approx;
    logic [2*W-1:0] out_prod;
    logic          cnt_clr;
    logic [CW-1:0] approx_cnt;

    logic          s_vld;
    logic [3:0]    s4_x, s4_y;
    logic          s4_ready, s4_ov, s4_oa;
    logic [7:0]    s4_prod;
    logic [15:0]   s4_cnt;
    logic [11:0]   s12_x, s12_y;
    logic          s12_ready, s12_ov, s12_oa;
    logic [23:0]   s12_prod;
    logic [15:0]   s12_cnt;

    int checks = 0;
    int failures = 0;

    logic [63:0] qp8[$];
    logic        qa8[$];
    logic [63:0] q4[$];
    logic [63:0] q12[$];

    always #5 clk = ~clk;

    approx_mul_ha_pipe #(.W(W), .APPROX_COLS(AC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_approx(in_approx), .out_valid(out_valid),
        .out_ready(out_ready), .out_prod(out_prod), .out_approx(out_approx),
        .cnt_clr(cnt_clr), .approx_cnt(approx_cnt)
    );

    approx_mul_ha_pipe #(.W(4), .APPROX_COLS(2)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_vld), .in_ready(s4_ready),
        .in_x(s4_x), .in_y(s4_y), .in_approx(1'b0), .out_valid(s4_ov),
        .out_ready(1'b1), .out_prod(s4_prod), .out_approx(s4_oa),
        .cnt_clr(1'b0), .approx_cnt(s4_cnt)
    );

    approx_mul_ha_pipe #(.W(12), .APPROX_COLS(3)) u_w12 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_vld), .in_ready(s12_ready),
        .in_x(s12_x), .in_y(s12_y), .in_approx(1'b0), .out_valid(s12_ov),
        .out_ready(1'b1), .out_prod(s12_prod), .out_approx(s12_oa),
        .cnt_clr(1'b0), .approx_cnt(s12_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Exact product minus 2^(j+2k) for every colliding column j < ac of every pair k.
    function automatic logic [63:0] model(input int w, input int ac, input logic [63:0] x,
                                          input logic [63:0] y, input logic apx);
        logic [63:0] p;
        p = x * y;
        if (apx) begin
            for (int k = 0; k < w / 2; k++) begin
                if (x[2*k] && x[2*k+1]) begin
                    for (int j = 1; j < ac && j < w; j++) begin
                        if (y[j] && y[j-1]) p = p - (64'(1) << (j + 2 * k));
                    end
                end
            end
        end
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (qp8.size() == 0) chk("w8_unexpected_output", 64'(out_prod), 64'(0));
            else begin
                chk("w8_prod", 64'(out_prod), qp8.pop_front());
                chk("w8_mode", 64'(out_approx), 64'(qa8.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s4_ov) begin
            if (q4.size() == 0) chk("w4_unexpected_output", 64'(s4_prod), 64'(0));
            else begin
                chk("w4_prod", 64'(s4_prod), q4.pop_front());
                chk("w4_mode", 64'(s4_oa), 64'(0));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s12_ov) begin
            if (q12.size() == 0) chk("w12_unexpected_output", 64'(s12_prod), 64'(0));
            else begin
                chk("w12_prod", 64'(s12_prod), q12.pop_front());
                chk("w12_mode", 64'(s12_oa), 64'(0));
            end
        end
    end

    task automatic send(input logic apx, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [63:0] exp);
        bit acc;
        int n;
        in_x = x;
        in_y = y;
        in_approx = apx;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                qp8.push_back(exp);
                qa8.push_back(apx);
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((qp8.size() + q4.size() + q12.size()) != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", 64'(qp8.size() + q4.size() + q12.size()), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rx, ry;
        logic         ra;
        int           n, stale;

        in_valid = 0; in_x = '0; in_y = '0; in_approx = 0;
        out_ready = 1; cnt_clr = 0;
        s_vld = 0; s4_x = '0; s4_y = '0; s12_x = '0; s12_y = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_prod", 64'(out_prod), 64'(0));
        chk("rst_out_approx", 64'(out_approx), 64'(0));
        chk("rst_cnt", 64'(approx_cnt), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;

        // Latency: accepted at edge N, visible after edge N+3
        send(1'b0, 8'd255, 8'd255, 64'd65025);
        @(posedge clk); #1;
        chk("lat_n1_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk("lat_n2_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk("lat_n3_valid", 64'(out_valid), 64'(1));
        wait_drain();
        chk("cnt_after_exact", 64'(approx_cnt), 64'(0));

        send(1'b1, 8'd255, 8'd255, 64'd64515);
        wait_drain();
        chk("cnt_after_approx", 64'(approx_cnt), 64'(1));

        // Back-to-back mixed modes
        send(1'b1, 8'd3, 8'd3, 64'd7);
        send(1'b1, 8'd3, 8'd1, 64'd3);
        send(1'b0, 8'd3, 8'd3, 64'd9);
        send(1'b1, 8'd3, 8'd2, 64'd6);
        wait_drain();
        chk("cnt_after_mix", 64'(approx_cnt), 64'(4));

        // Backpressure mid-stream
        send(1'b1, 8'd255, 8'd255, 64'd64515);
        send(1'b0, 8'd12, 8'd34, 64'd408);
        send(1'b1, 8'd200, 8'd100, 64'd20000);
        out_ready = 1'b0;
        send(1'b0, 8'd7, 8'd9, 64'd63);
        chk("bp_valid", 64'(out_valid), 64'(1));
        fork
            begin
                repeat (4) begin
                    @(posedge clk); #1;
                    chk("bp_prod_hold", 64'(out_prod), 64'd64515);
                    chk("bp_in_ready", 64'(in_ready), 64'(0));
                end
                out_ready = 1'b1;
            end
            send(1'b1, 8'd15, 8'd7, 64'd75);
        join
        wait_drain();
        chk("cnt_after_bp", 64'(approx_cnt), 64'(7));

        // Saturation of the 4-bit counter
        for (int i = 0; i < 10; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            send(1'b1, rx, ry, model(W, AC, 64'(rx), 64'(ry), 1'b1));
        end
        wait_drain();
        chk("cnt_saturated", 64'(approx_cnt), 64'(15));

        // Clear wins over a simultaneous approx handshake
        send(1'b1, 8'd255, 8'd255, 64'd64515);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("clr_wait_valid", 64'(out_valid), 64'(1));
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("cnt_clr_priority", 64'(approx_cnt), 64'(0));
        send(1'b1, 8'd3, 8'd3, 64'd7);
        wait_drain();
        chk("cnt_after_clr", 64'(approx_cnt), 64'(1));

        // Async reset with three beats in flight
        out_ready = 1'b0;
        send(1'b1, 8'd255, 8'd255, 64'd64515);
        send(1'b1, 8'd15, 8'd7, 64'd75);
        send(1'b0, 8'd12, 8'd34, 64'd408);
        @(posedge clk); #1;
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        qp8.delete();
        qa8.delete();
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_cnt", 64'(approx_cnt), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        chk("post_rst_stale", 64'(stale), 64'(0));
        send(1'b0, 8'd100, 8'd200, 64'd20000);
        wait_drain();

        // Random streams: mixed modes at W=8, exact at W=4 and W=12
        for (int i = 0; i < 10000; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            ra = 1'($urandom);
            in_x = rx; in_y = ry; in_approx = ra; in_valid = 1'b1;
            s4_x = 4'($urandom); s4_y = 4'($urandom);
            s12_x = 12'($urandom); s12_y = 12'($urandom);
            s_vld = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                qp8.push_back(model(W, AC, 64'(rx), 64'(ry), ra));
                qa8.push_back(ra);
            end
            if (s4_ready) q4.push_back(model(4, 2, 64'(s4_x), 64'(s4_y), 1'b0));
            if (s12_ready) q12.push_back(model(12, 3, 64'(s12_x), 64'(s12_y), 1'b0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        s_vld = 1'b0;
        wait_drain();
        chk("w4_cnt_exact_only", 64'(s4_cnt), 64'(0));
        chk("w12_cnt_exact_only", 64'(s12_cnt), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
